// File: rtl/alu_sched_pkg.sv
// Shared types and defaults for the ALU issue scheduler.
// Imported by the scheduler top and its arbiter.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OPW_DEF       = 7;
  localparam int LAT_SHORT_DEF = 1;
  localparam int LAT_LONG_DEF  = 4;
  localparam int LONG_BIT      = 6;
  localparam int CNT_W         = 4;

  function automatic logic [CNT_W-1:0] lat_sel(
    input logic is_long,
    input int   lat_s,
    input int   lat_l
  );
    return is_long ? CNT_W'(lat_l) : CNT_W'(lat_s);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: the pointer names the preferred
// requester, the other one wins only when the preferred is idle.
module rr_arb2
  import alu_sched_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  logic alt;

  assign alt = ~ptr;

  always_comb begin
    grant = 2'b00;
    priority case (1'b1)
      valid[ptr]: grant[ptr] = 1'b1;
      valid[alt]: grant[alt] = 1'b1;
      default:    grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Single-issue ALU scheduler: arbitrates two requesters, runs one op
// for a fixed latency, then holds a response until it is accepted.
module alu_issue_sched
  import alu_sched_pkg::*;
#(
  parameter int OPW       = OPW_DEF,
  parameter int LAT_SHORT = LAT_SHORT_DEF,
  parameter int LAT_LONG  = LAT_LONG_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [OPW-1:0] req1_op,
  output logic [OPW-1:0] alu_op,
  output logic           alu_en,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  busy
);

  if (LAT_SHORT < 1 || LAT_SHORT > 15) begin : g_bad_short
    $error("LAT_SHORT must be in 1..15");
  end
  if (LAT_LONG < 1 || LAT_LONG > 15) begin : g_bad_long
    $error("LAT_LONG must be in 1..15");
  end
  if (OPW <= LONG_BIT) begin : g_bad_opw
    $error("OPW too narrow for the long-op bit");
  end

  state_t           state;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt;
  logic             ptr;

  logic [1:0]       grant;
  logic             xfer;
  logic             gid;
  logic [OPW-1:0]   op_in;
  logic [CNT_W-1:0] lat_in;

  rr_arb2 u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // ready is gated by rst so nothing looks accepted while in reset
  assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign xfer      = |req_ready;
  assign gid       = grant[1];
  assign op_in     = gid ? req1_op : req0_op;
  assign lat_in    = lat_sel(op_in[LONG_BIT], LAT_SHORT, LAT_LONG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      id_q  <= 1'b0;
      cnt   <= '0;
      ptr   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            op_q  <= op_in;
            id_q  <= gid;
            cnt   <= lat_in;
            ptr   <= ~gid;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_en    = (state == EXEC);
  assign alu_op    = alu_en ? op_q : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_valid & id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference.
module tb_alu_issue_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [6:0] req0_op = '0;
  logic [6:0] req1_op = '0;
  logic [6:0] alu_op;
  logic       alu_en;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic       busy;

  int ntests = 0;
  int nfail  = 0;
  int en_cnt = 0;

  // reference: remaining exec cycles, pending response, preferred requester
  int         m_left = 0;
  bit         m_resp = 1'b0;
  bit         m_ptr  = 1'b0;
  logic [6:0] m_op   = '0;
  bit         m_id   = 1'b0;

  alu_issue_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .alu_op    (alu_op),
    .alu_en    (alu_en),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [6:0] o);
    return o[6] ? 4 : 1;
  endfunction

  task automatic cycle(input logic [1:0] v, input logic [6:0] o0,
                       input logic [6:0] o1, input logic rr);
    bit         idle;
    int         gi;
    logic [1:0] e_ready;
    @(negedge clk);
    req_valid = v;
    req0_op   = o0;
    req1_op   = o1;
    rsp_ready = rr;
    #1;
    idle = (m_left == 0) && !m_resp;
    gi = -1;
    if (idle) begin
      if (v[m_ptr]) gi = int'(m_ptr);
      else if (v[!m_ptr]) gi = int'(!m_ptr);
    end
    e_ready = (gi < 0) ? 2'b00 : (gi == 0 ? 2'b01 : 2'b10);
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("alu_en", 32'(alu_en), 32'(m_left > 0));
    chk("alu_op", 32'(alu_op), (m_left > 0) ? 32'(m_op) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    chk("rsp_id", 32'(rsp_id), m_resp ? 32'(m_id) : 32'd0);
    chk("busy", 32'(busy), 32'(!idle));
    if (alu_en) en_cnt++;
    if (gi >= 0) begin
      m_op   = (gi == 1) ? o1 : o0;
      m_id   = (gi == 1);
      m_left = lat_of(m_op);
      m_ptr  = (gi == 0);
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_resp = 1'b1;
    end else if (m_resp && rr) begin
      m_resp = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    m_left = 0;
    m_resp = 1'b0;
    m_ptr  = 1'b0;
    m_op   = '0;
    m_id   = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    rst       = 1'b0;
  endtask

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  initial begin
    do_reset();

    cycle(2'b01, 7'h05, 7'h00, 1'b1);
    cycle(2'b01, 7'h05, 7'h00, 1'b1);
    cycle(2'b00, 7'h05, 7'h00, 1'b1);
    cycle(2'b00, 7'h00, 7'h00, 1'b1);

    for (int i = 0; i < 16; i++)
      cycle(2'b11, rnd_op() & 7'h3f, rnd_op() & 7'h3f, 1'b1);

    do_reset();
    en_cnt = 0;
    cycle(2'b10, 7'h00, 7'h45, 1'b1);
    for (int i = 0; i < 6; i++)
      cycle(2'b00, 7'h00, 7'h00, 1'b1);
    chk("long_en_cycles", 32'(en_cnt), 32'd4);

    cycle(2'b01, 7'h03, 7'h00, 1'b1);
    cycle(2'b11, 7'h11, 7'h22, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(2'b11, rnd_op(), rnd_op(), 1'b0);
    cycle(2'b11, 7'h00, 7'h00, 1'b1);
    cycle(2'b00, 7'h00, 7'h00, 1'b1);

    cycle(2'b01, 7'h4a, 7'h00, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle(2'($urandom_range(0, 3)), rnd_op(), rnd_op(), 1'b1);
    cycle(2'b00, 7'h00, 7'h00, 1'b1);

    do_reset();
    cycle(2'b01, 7'h45, 7'h00, 1'b1);
    cycle(2'b00, 7'h45, 7'h00, 1'b1);
    do_reset();
    cycle(2'b11, 7'h01, 7'h02, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle(2'b00, 7'h00, 7'h00, 1'b1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(2'($urandom_range(0, 3)), rnd_op(), rnd_op(),
            $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
